// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter, latches ROM bytes into an instruction
// register and presents them downstream over valid/ready, with jump and halt.
module instr_fetch #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic [7:0] instr_pc,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_instr_pc;
  logic [3:0] r_opcode;
  logic [3:0] r_operand;
  logic       r_valid;
  logic       r_halted;

  logic       w_xfer;
  logic       w_capture;

  assign w_xfer    = r_valid & instr_ready;
  assign w_capture = ~r_valid | w_xfer;

  // Jump always wins over capture and over the HLT transfer; HALTED ignores it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_instr_pc <= 8'h00;
      r_opcode   <= 4'h0;
      r_operand  <= 4'h0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (jump_en) begin
            r_pc    <= jump_addr;
            r_valid <= 1'b0;
          end else if (w_capture) begin
            r_opcode   <= rom_data[7:4];
            r_operand  <= rom_data[3:0];
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 8'd1;
            if (rom_data[7:4] == HLT_OPCODE)
              r_state <= HALT_PEND;
          end
        end
        HALT_PEND: begin
          if (jump_en) begin
            r_pc    <= jump_addr;
            r_valid <= 1'b0;
            r_state <= RUN;
          end else if (w_xfer) begin
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= HALTED;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign rom_addr    = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_valid;
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;

endmodule
